threshold_sequencer: RTL and testbench

//  Top-level phase controller for the adaptive-threshold pipeline.
//  - Runs the box_filter pass (image ROM -> threshold RAM), then the threshold pass (ROM + RAM -> display).
//  - Owns the image-ROM address mux, start pulses, completion tracking, watchdog, frame count and LED status.
//  - Sits between the top level and the box_filter/threshold instances.

---
 rtl/threshold_pkg.sv | 23 ++
 rtl/pass_watchdog.sv | 41 ++++
 rtl/threshold_sequencer.sv | 156 +++++++++++++++
 tb/tb_threshold_sequencer.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/threshold_pkg.sv
// Shared constants for the adaptive-threshold phase sequencer:
// state encodings, stale-finished guard length and status LED bit positions.
package threshold_pkg;

  localparam logic [2:0] SEQ_IDLE      = 3'd0;
  localparam logic [2:0] SEQ_BOX_START = 3'd1;
  localparam logic [2:0] SEQ_BOX_RUN   = 3'd2;
  localparam logic [2:0] SEQ_THR_START = 3'd3;
  localparam logic [2:0] SEQ_THR_RUN   = 3'd4;
  localparam logic [2:0] SEQ_DONE      = 3'd5;
  localparam logic [2:0] SEQ_ERROR     = 3'd6;

  localparam int GUARD_CYCLES = 2;
  localparam int GUARD_W      = $clog2(GUARD_CYCLES + 1);

  localparam int LED_IDLE     = 0;
  localparam int LED_BOX      = 1;
  localparam int LED_THR      = 2;
  localparam int LED_FRAME    = 3;
  localparam int LED_COUNT_LO = 4;
  localparam int LED_ERROR    = 9;

endpackage

// File: rtl/pass_watchdog.sv
// Per-pass guard and timeout counters, shared by the box and threshold passes.
// Ports: clock, reset (sync, high), clear (pass start), enable (pass running),
//        guard_done (finished may be trusted), expired (timeout reached this cycle).
module pass_watchdog
  import threshold_pkg::*;
#(
  parameter int TIMEOUT_BITS = 20
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic guard_done,
  output logic expired
);

  // expired fires on the run cycle that moves the counter to all-ones
  localparam logic [TIMEOUT_BITS-1:0] TMO_LAST =
    {{(TIMEOUT_BITS-1){1'b1}}, 1'b0};

  logic [GUARD_W-1:0]      guard;
  logic [TIMEOUT_BITS-1:0] tmo;

  always_ff @(posedge clock) begin
    if (reset) begin
      guard <= '0;
      tmo   <= '0;
    end else if (clear) begin
      guard <= GUARD_W'(GUARD_CYCLES);
      tmo   <= '0;
    end else if (enable) begin
      if (guard != '0)
        guard <= guard - 1'b1;
      tmo <= tmo + 1'b1;
    end
  end

  assign guard_done = (guard == '0);
  assign expired    = enable && (tmo == TMO_LAST);

endmodule

// File: rtl/threshold_sequencer.sv
// Phase controller: box_filter pass, then threshold pass, with start pulses,
// image-ROM address mux, watchdog, frame counter and status LEDs.
// Ports: clock/reset (sync, high); iStart/iContinuous run control;
//        oBoxStart/iBoxFinished and oThrStart/iThrFinished pass handshakes;
//        i*Image* address requests muxed onto oImageCol/oImageRow;
//        oBusy/oDone/oError/oFrameCount/oState/LEDR status.
module threshold_sequencer
  import threshold_pkg::*;
#(
  parameter int WIDTH_BITS   = 8,
  parameter int HEIGHT_BITS  = 8,
  parameter int TIMEOUT_BITS = 20,
  parameter int FRAME_BITS   = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   iStart,
  input  logic                   iContinuous,
  output logic                   oBoxStart,
  input  logic                   iBoxFinished,
  output logic                   oThrStart,
  input  logic                   iThrFinished,
  input  logic [WIDTH_BITS-1:0]  iBoxImageCol,
  input  logic [HEIGHT_BITS-1:0] iBoxImageRow,
  input  logic [WIDTH_BITS-1:0]  iThrImageCol,
  input  logic [HEIGHT_BITS-1:0] iThrImageRow,
  output logic [WIDTH_BITS-1:0]  oImageCol,
  output logic [HEIGHT_BITS-1:0] oImageRow,
  output logic                   oBusy,
  output logic                   oDone,
  output logic                   oError,
  output logic [FRAME_BITS-1:0]  oFrameCount,
  output logic [2:0]             oState,
  output logic [9:0]             LEDR
);

  logic [2:0]            state;
  logic [2:0]            nxt;
  logic                  in_start;
  logic                  in_run;
  logic                  in_thr;
  logic                  guard_done;
  logic                  expired;
  logic                  box_start;
  logic                  thr_start;
  logic                  done;
  logic                  error;
  logic                  frame_seen;
  logic [FRAME_BITS-1:0] frame_count;
  logic [4:0]            frame_led;
  logic [9:0]            led;
  logic [9:0]            led_next;

  assign in_start = (state == SEQ_BOX_START) ||
                    (state == SEQ_THR_START);
  assign in_run   = (state == SEQ_BOX_RUN) ||
                    (state == SEQ_THR_RUN);
  assign in_thr   = (state == SEQ_THR_START) ||
                    (state == SEQ_THR_RUN);

  pass_watchdog #(
    .TIMEOUT_BITS(TIMEOUT_BITS)
  ) u_watchdog (
    .clock      (clock),
    .reset      (reset),
    .clear      (in_start),
    .enable     (in_run),
    .guard_done (guard_done),
    .expired    (expired)
  );

  // finished is checked before expiry so a pass ending on
  // its last allowed cycle still completes
  always_comb begin
    nxt = state;
    unique case (state)
      SEQ_IDLE:
        if (iStart) nxt = SEQ_BOX_START;
      SEQ_BOX_START:
        nxt = SEQ_BOX_RUN;
      SEQ_BOX_RUN:
        if (iBoxFinished && guard_done)
          nxt = SEQ_THR_START;
        else if (expired)
          nxt = SEQ_ERROR;
      SEQ_THR_START:
        nxt = SEQ_THR_RUN;
      SEQ_THR_RUN:
        if (iThrFinished && guard_done)
          nxt = SEQ_DONE;
        else if (expired)
          nxt = SEQ_ERROR;
      SEQ_DONE:
        nxt = iContinuous ? SEQ_BOX_START : SEQ_IDLE;
      SEQ_ERROR:
        nxt = SEQ_ERROR;
      default:
        nxt = SEQ_IDLE;
    endcase
  end

  if (FRAME_BITS >= 5) begin : g_led_wide
    assign frame_led = frame_count[4:0];
  end else begin : g_led_narrow
    assign frame_led = {{(5-FRAME_BITS){1'b0}}, frame_count};
  end

  // LEDs are built from the registered state, giving a one-cycle lag
  always_comb begin
    led_next                       = '0;
    led_next[LED_IDLE]             = (state == SEQ_IDLE);
    led_next[LED_BOX]              = (state == SEQ_BOX_START) ||
                                     (state == SEQ_BOX_RUN);
    led_next[LED_THR]              = in_thr;
    led_next[LED_FRAME]            = frame_seen;
    led_next[LED_COUNT_LO +: 5]    = frame_led;
    led_next[LED_ERROR]            = error;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= SEQ_IDLE;
      box_start   <= 1'b0;
      thr_start   <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      frame_seen  <= 1'b0;
      frame_count <= '0;
      led         <= 10'b0000000001;
    end else begin
      state     <= nxt;
      box_start <= (nxt == SEQ_BOX_START);
      thr_start <= (nxt == SEQ_THR_START);
      done      <= (nxt == SEQ_DONE);
      if (nxt == SEQ_ERROR)
        error <= 1'b1;
      if (nxt == SEQ_DONE) begin
        frame_count <= frame_count + 1'b1;
        frame_seen  <= 1'b1;
      end
      led <= led_next;
    end
  end

  assign oImageCol   = in_thr ? iThrImageCol : iBoxImageCol;
  assign oImageRow   = in_thr ? iThrImageRow : iBoxImageRow;
  assign oBoxStart   = box_start;
  assign oThrStart   = thr_start;
  assign oBusy       = in_start || in_run;
  assign oDone       = done;
  assign oError      = error;
  assign oFrameCount = frame_count;
  assign oState      = state;
  assign LEDR        = led;

endmodule

// File: tb/tb_threshold_sequencer.sv
// Bench for threshold_sequencer: a default-sized instance and a small one
// (4-bit watchdog, 2-bit frame counter), both tracked by a reference model.
module tb_threshold_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // instance A: default parameters
  logic       a_rst = 1'b1, a_start = 1'b0, a_cont = 1'b0;
  logic       a_bf = 1'b0, a_tf = 1'b0;
  logic [7:0] a_bc = 8'h0, a_br = 8'h0, a_tc = 8'h0, a_tr = 8'h0;
  logic       a_bs, a_ts, a_busy, a_done, a_err;
  logic [7:0] a_col, a_row, a_fc;
  logic [2:0] a_st;
  logic [9:0] a_led;

  // instance B: short watchdog, narrow frame counter
  logic       b_rst = 1'b1, b_start = 1'b0, b_cont = 1'b0;
  logic       b_bf = 1'b0, b_tf = 1'b0;
  logic [7:0] b_bc = 8'h0, b_br = 8'h0, b_tc = 8'h0, b_tr = 8'h0;
  logic       b_bs, b_ts, b_busy, b_done, b_err;
  logic [7:0] b_col, b_row;
  logic [1:0] b_fc;
  logic [2:0] b_st;
  logic [9:0] b_led;

  threshold_sequencer dut_a (
    .clock(clk), .reset(a_rst), .iStart(a_start),
    .iContinuous(a_cont), .oBoxStart(a_bs),
    .iBoxFinished(a_bf), .oThrStart(a_ts),
    .iThrFinished(a_tf), .iBoxImageCol(a_bc),
    .iBoxImageRow(a_br), .iThrImageCol(a_tc),
    .iThrImageRow(a_tr), .oImageCol(a_col),
    .oImageRow(a_row), .oBusy(a_busy), .oDone(a_done),
    .oError(a_err), .oFrameCount(a_fc), .oState(a_st),
    .LEDR(a_led)
  );

  threshold_sequencer #(
    .TIMEOUT_BITS(4), .FRAME_BITS(2)
  ) dut_b (
    .clock(clk), .reset(b_rst), .iStart(b_start),
    .iContinuous(b_cont), .oBoxStart(b_bs),
    .iBoxFinished(b_bf), .oThrStart(b_ts),
    .iThrFinished(b_tf), .iBoxImageCol(b_bc),
    .iBoxImageRow(b_br), .iThrImageCol(b_tc),
    .iThrImageRow(b_tr), .oImageCol(b_col),
    .oImageRow(b_row), .oBusy(b_busy), .oDone(b_done),
    .oError(b_err), .oFrameCount(b_fc), .oState(b_st),
    .LEDR(b_led)
  );

  // ---------------- reference model ----------------
  // phase numbers follow the published state encoding;
  // runs counts completed cycles of the current pass
  typedef struct {
    int       ph;
    int       runs;
    int       frames;
    bit       seen;
    bit       err;
    bit [9:0] led;
  } model_t;

  typedef struct packed {
    logic [2:0] st;
    logic       bs;
    logic       ts;
    logic       dn;
    logic       busy;
    logic       err;
    logic [7:0] fc;
    logic [7:0] col;
    logic [7:0] row;
    logic [9:0] led;
  } obs_t;

  model_t ma = '{0, 0, 0, 1'b0, 1'b0, 10'd1};
  model_t mb = '{0, 0, 0, 1'b0, 1'b0, 10'd1};

  function automatic bit [9:0] led_of(model_t m);
    bit [9:0] l;
    l    = '0;
    l[0] = (m.ph == 0);
    l[1] = (m.ph == 1 || m.ph == 2);
    l[2] = (m.ph == 3 || m.ph == 4);
    l[3] = m.seen;
    l[8:4] = 5'(m.frames % 32);
    l[9] = m.err;
    return l;
  endfunction

  function automatic model_t step(model_t m, bit rst, bit start,
                                  bit cont, bit bf, bit tf,
                                  int tbits, int fbits);
    model_t r;
    int     limit;
    bit     fin;
    r = m;
    limit = (1 << tbits) - 1;
    if (rst) begin
      r = '{0, 0, 0, 1'b0, 1'b0, 10'd1};
      return r;
    end
    r.led = led_of(m);
    case (m.ph)
      0: if (start) r.ph = 1;
      1, 3: begin
        r.ph = m.ph + 1;
        r.runs = 0;
      end
      2, 4: begin
        fin = (m.ph == 2) ? bf : tf;
        if (fin && m.runs >= 2) r.ph = m.ph + 1;
        else if (m.runs + 1 >= limit) r.ph = 6;
        else r.runs = m.runs + 1;
      end
      5: r.ph = cont ? 1 : 0;
      default: ;
    endcase
    if (r.ph == 5) begin
      r.frames = (m.frames + 1) % (1 << fbits);
      r.seen = 1'b1;
    end
    if (r.ph == 6) r.err = 1'b1;
    return r;
  endfunction

  function automatic obs_t expect_obs(model_t m, logic [7:0] bc,
                                      logic [7:0] br, logic [7:0] tc,
                                      logic [7:0] tr);
    obs_t o;
    bit   thr;
    thr    = (m.ph == 3 || m.ph == 4);
    o.st   = 3'(m.ph);
    o.bs   = (m.ph == 1);
    o.ts   = (m.ph == 3);
    o.dn   = (m.ph == 5);
    o.busy = (m.ph >= 1 && m.ph <= 4);
    o.err  = m.err;
    o.fc   = 8'(m.frames);
    o.col  = thr ? tc : bc;
    o.row  = thr ? tr : br;
    o.led  = m.led;
    return o;
  endfunction

  task automatic cmp_obs(string tag, obs_t act, obs_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got st=%0d bs=%0b ts=%0b dn=%0b busy=%0b err=%0b fc=%0d col=%h row=%h led=%b required st=%0d bs=%0b ts=%0b dn=%0b busy=%0b err=%0b fc=%0d col=%h row=%h led=%b",
        tag, cyc, act.st, act.bs, act.ts, act.dn, act.busy, act.err,
        act.fc, act.col, act.row, act.led, exp.st, exp.bs, exp.ts,
        exp.dn, exp.busy, exp.err, exp.fc, exp.col, exp.row, exp.led);
    end
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got %0h required %0h", name, cyc, act, exp);
    end
  endtask

  // one clock: advance both models on the edge, compare both DUTs after it
  task automatic tick();
    obs_t act;
    @(posedge clk);
    ma = step(ma, a_rst, a_start, a_cont, a_bf, a_tf, 20, 8);
    mb = step(mb, b_rst, b_start, b_cont, b_bf, b_tf, 4, 2);
    cyc++;
    #1;
    act = '{st:a_st, bs:a_bs, ts:a_ts, dn:a_done, busy:a_busy,
            err:a_err, fc:a_fc, col:a_col, row:a_row, led:a_led};
    cmp_obs("model_a", act, expect_obs(ma, a_bc, a_br, a_tc, a_tr));
    act = '{st:b_st, bs:b_bs, ts:b_ts, dn:b_done, busy:b_busy,
            err:b_err, fc:{6'd0, b_fc}, col:b_col, row:b_row,
            led:b_led};
    cmp_obs("model_b", act, expect_obs(mb, b_bc, b_br, b_tc, b_tr));
  endtask

  task automatic reset_a();
    a_rst = 1'b1;
    tick();
    a_rst = 1'b0;
  endtask

  task automatic reset_b();
    b_rst = 1'b1;
    tick();
    b_rst = 1'b0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit start;
    bit cont;
    bit bf;
    bit tf;
    int st;
    bit bs;
    bit ts;
    bit dn;
    int fc;
  } row_t;

  row_t tbl[20];

  initial begin
    int first_bs, first_ts, nbs, nts, ndn, nrun, bcnt, tcnt;
    bit prev_done;

    // stale finished high from the start; iStart/iContinuous
    // toggled where they must be ignored
    tbl[0]  = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
    tbl[1]  = '{1, 1, 1, 1, 2, 0, 0, 0, 0};
    tbl[2]  = '{1, 0, 1, 1, 2, 0, 0, 0, 0};
    tbl[3]  = '{0, 0, 1, 1, 2, 0, 0, 0, 0};
    tbl[4]  = '{0, 0, 1, 1, 3, 0, 1, 0, 0};
    tbl[5]  = '{0, 0, 1, 1, 4, 0, 0, 0, 0};
    tbl[6]  = '{0, 0, 1, 1, 4, 0, 0, 0, 0};
    tbl[7]  = '{0, 0, 1, 1, 4, 0, 0, 0, 0};
    tbl[8]  = '{0, 0, 1, 1, 5, 0, 0, 1, 1};
    tbl[9]  = '{0, 1, 0, 0, 1, 1, 0, 0, 1};
    tbl[10] = '{0, 0, 0, 0, 2, 0, 0, 0, 1};
    tbl[11] = '{0, 0, 1, 0, 2, 0, 0, 0, 1};
    tbl[12] = '{0, 0, 1, 0, 2, 0, 0, 0, 1};
    tbl[13] = '{0, 0, 1, 0, 3, 0, 1, 0, 1};
    tbl[14] = '{0, 0, 0, 1, 4, 0, 0, 0, 1};
    tbl[15] = '{0, 0, 0, 1, 4, 0, 0, 0, 1};
    tbl[16] = '{0, 0, 0, 1, 4, 0, 0, 0, 1};
    tbl[17] = '{0, 0, 0, 1, 5, 0, 0, 1, 2};
    tbl[18] = '{1, 0, 0, 0, 0, 0, 0, 0, 2};
    tbl[19] = '{0, 0, 0, 0, 0, 0, 0, 0, 2};

    // reset state
    tick();
    tick();
    check("rst.state", a_st, 0);
    check("rst.led", a_led, 10'b0000000001);
    check("rst.pulses", {a_bs, a_ts, a_done, a_err}, 0);
    check("rst.frames", a_fc, 0);
    a_rst = 1'b0;
    b_rst = 1'b0;

    // table: guard, pulses, continuous restart, return to idle
    first_bs = -1;
    first_ts = -1;
    for (int i = 0; i < 20; i++) begin
      a_start = tbl[i].start;
      a_cont  = tbl[i].cont;
      a_bf    = tbl[i].bf;
      a_tf    = tbl[i].tf;
      tick();
      check($sformatf("tbl%0d.state", i), a_st, tbl[i].st);
      check($sformatf("tbl%0d.boxstart", i), a_bs, tbl[i].bs);
      check($sformatf("tbl%0d.thrstart", i), a_ts, tbl[i].ts);
      check($sformatf("tbl%0d.done", i), a_done, tbl[i].dn);
      check($sformatf("tbl%0d.frames", i), a_fc, tbl[i].fc);
      if (a_bs && first_bs < 0) first_bs = i;
      if (a_ts && first_ts < 0) first_ts = i;
    end
    check("guard.gap", first_ts - first_bs, 4);
    a_start = 0; a_cont = 0; a_bf = 0; a_tf = 0;

    // single frame with slow sub-blocks
    reset_a();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    bcnt = -1; tcnt = -1; nbs = 0; nts = 0; ndn = 0;
    for (int k = 0; k < 400 && ndn == 0; k++) begin
      if (a_bs) begin
        nbs++; a_bf = 1'b0; bcnt = 0;
      end else if (bcnt >= 0) begin
        bcnt++;
        if (bcnt == 100) a_bf = 1'b1;
      end
      if (a_ts) begin
        nts++; a_tf = 1'b0; tcnt = 0;
      end else if (tcnt >= 0) begin
        tcnt++;
        if (tcnt == 50) a_tf = 1'b1;
      end
      if (a_done) ndn++;
      tick();
    end
    check("frame1.boxstarts", nbs, 1);
    check("frame1.thrstarts", nts, 1);
    check("frame1.dones", ndn, 1);
    check("frame1.count", a_fc, 1);
    check("frame1.idle", a_st, 0);
    check("frame1.led3", a_led[3], 1);
    a_bf = 0; a_tf = 0;

    // address mux
    reset_a();
    a_bc = 8'h12; a_br = 8'h34; a_tc = 8'hAB; a_tr = 8'hCD;
    a_bf = 1'b1; a_tf = 1'b1;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (ma.ph == 3 || ma.ph == 4)
        check("mux.thr", {a_col, a_row}, 16'hABCD);
      else
        check("mux.box", {a_col, a_row}, 16'h1234);
      tick();
    end

    // continuous mode, three frames
    reset_a();
    a_cont = 1'b1;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int k = 0; k < 100 && ma.frames < 3; k++) begin
      prev_done = a_done;
      tick();
      if (prev_done) check("cont.restart", a_st, 1);
    end
    a_cont = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    check("cont.frames", a_fc, 3);
    check("cont.idle", a_st, 0);

    // frame counter wrap on the narrow instance
    reset_b();
    b_bf = 1'b1; b_tf = 1'b1; b_cont = 1'b1;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    ndn = 0;
    for (int k = 0; k < 200 && ndn < 5; k++) begin
      tick();
      if (b_done) ndn++;
    end
    b_cont = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    check("wrap.dones", ndn, 5);
    check("wrap.frames", b_fc, 1);

    // reset in the middle of a box pass
    a_bf = 1'b0; a_tf = 1'b0;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    check("midrst.inrun", a_st, 2);
    a_rst = 1'b1;
    tick();
    a_rst = 1'b0;
    check("midrst.state", a_st, 0);
    check("midrst.pulses", {a_bs, a_ts, a_done}, 0);
    check("midrst.frames", a_fc, 0);
    tick();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    check("midrst.restart", {a_bs, a_st}, {1'b1, 3'd1});

    // watchdog on the short instance
    reset_b();
    b_bf = 1'b1; b_tf = 1'b0;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    nrun = 0;
    for (int k = 0; k < 100 && b_st != 3'd6; k++) begin
      tick();
      if (b_st == 3'd4) nrun++;
    end
    check("wdog.runcycles", nrun, 15);
    check("wdog.state", b_st, 6);
    check("wdog.error", b_err, 1);
    check("wdog.thrstart", b_ts, 0);
    tick();
    check("wdog.led9", b_led[9], 1);
    b_start = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    b_start = 1'b0;
    check("wdog.absorb", {b_st, b_bs}, {3'd6, 1'b0});
    reset_b();
    check("wdog.rststate", b_st, 0);
    check("wdog.rsterror", b_err, 0);

    // randomized traffic on both instances
    for (int k = 0; k < 3000; k++) begin
      a_rst   = ($urandom_range(99) == 0);
      a_start = ($urandom_range(3) == 0);
      a_cont  = $urandom_range(1);
      a_bf    = ($urandom_range(3) == 0);
      a_tf    = ($urandom_range(3) == 0);
      a_bc    = 8'($urandom); a_br = 8'($urandom);
      a_tc    = 8'($urandom); a_tr = 8'($urandom);
      b_rst   = ($urandom_range(59) == 0);
      b_start = ($urandom_range(2) == 0);
      b_cont  = $urandom_range(1);
      b_bf    = ($urandom_range(9) == 0);
      b_tf    = ($urandom_range(9) == 0);
      b_bc    = 8'($urandom); b_br = 8'($urandom);
      b_tc    = 8'($urandom); b_tr = 8'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
